// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan display: cathode glyphs,
// slot encodings and anode patterns (all active-low).
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_HUND = 2'd2,
    SLOT_DEAD = 2'd3
  } slot_e;

  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [3:0] AN_SLOT0 = 4'b1110;
  localparam logic [3:0] AN_SLOT1 = 4'b1101;
  localparam logic [3:0] AN_SLOT2 = 4'b1011;

endpackage

// File: rtl/bcd_display_scan_if.sv
// Digit-capture inputs and display-drive outputs of the scan display.
interface bcd_display_scan_if;
  logic       LOAD;
  logic [3:0] ONES;
  logic [3:0] TENS;
  logic [1:0] HUNDREDS;
  logic       EN;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  modport master (output LOAD, ONES, TENS, HUNDREDS, EN, input AN, SEG, DP);
  modport slave  (input LOAD, ONES, TENS, HUNDREDS, EN, output AN, SEG, DP);
endinterface

// File: rtl/bcd7seg_decoder.sv
// Combinational BCD nibble to active-low {g..a} cathode decoder.
// Non-BCD nibbles show 'E' and ignore the blank request.
module bcd7seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    if (nibble <= 4'd9 && blank) begin
      seg = SEG_BLANK;
    end else begin
      unique case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_E;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures BCD digits on LOAD and scans them onto a 4-digit common-anode
// display with a guard interval, optional leading-zero blanking and a dead slot.
module bcd_display_scan
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned GUARD       = 4,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  bcd_display_scan_if.slave   bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] PS_GUARD = PW'(GUARD);

  logic [PW-1:0] prescale_q, prescale_d;
  slot_e         slot_q, slot_d;
  logic [3:0]    hold_ones_q, hold_ones_d;
  logic [3:0]    hold_tens_q, hold_tens_d;
  logic [1:0]    hold_hund_q, hold_hund_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q;

  logic [3:0]    dec_nibble;
  logic          dec_blank;
  logic [6:0]    dec_seg;

  bcd7seg_decoder u_dec (
    .nibble (dec_nibble),
    .blank  (dec_blank),
    .seg    (dec_seg)
  );

  always_comb begin
    hold_ones_d = hold_ones_q;
    hold_tens_d = hold_tens_q;
    hold_hund_d = hold_hund_q;
    prescale_d  = prescale_q + 1'b1;
    slot_d      = slot_q;
    dec_nibble  = '0;
    dec_blank   = 1'b1;
    an_d        = AN_OFF;

    if (bus.LOAD) begin
      hold_ones_d = bus.ONES;
      hold_tens_d = bus.TENS;
      hold_hund_d = bus.HUNDREDS;
    end

    if (prescale_q == PS_MAX) begin
      prescale_d = '0;
      unique case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: slot_d = SLOT_HUND;
        SLOT_HUND: slot_d = SLOT_DEAD;
        default:   slot_d = SLOT_ONES;
      endcase
    end

    // Outputs derive from the current hold/slot state, so a capture that
    // coincides with a slot wrap is shown in the newly entered slot.
    unique case (slot_q)
      SLOT_ONES: begin
        dec_nibble = hold_ones_q;
        dec_blank  = 1'b0;
        an_d       = AN_SLOT0;
      end
      SLOT_TENS: begin
        dec_nibble = hold_tens_q;
        dec_blank  = BLANK_LZ && hold_hund_q == 2'd0 && hold_tens_q == 4'd0;
        an_d       = AN_SLOT1;
      end
      SLOT_HUND: begin
        dec_nibble = {2'b00, hold_hund_q};
        dec_blank  = BLANK_LZ && hold_hund_q == 2'd0;
        an_d       = AN_SLOT2;
      end
      default: begin
        dec_nibble = '0;
        dec_blank  = 1'b1;
        an_d       = AN_OFF;
      end
    endcase

    if (!bus.EN || prescale_q < PS_GUARD) an_d = AN_OFF;
    seg_d = dec_seg;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prescale_q  <= '0;
      slot_q      <= SLOT_ONES;
      hold_ones_q <= '0;
      hold_tens_q <= '0;
      hold_hund_q <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      prescale_q  <= prescale_d;
      slot_q      <= slot_d;
      hold_ones_q <= hold_ones_d;
      hold_tens_q <= hold_tens_d;
      hold_hund_q <= hold_hund_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= 1'b1;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan: a behavioural reference model pushes
// the expected registered outputs per cycle, popped after each clock edge.
module tb_bcd_display_scan;

  localparam int unsigned DIV = 8;
  localparam int unsigned GRD = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  bcd_display_scan_if bus ();

  bcd_display_scan #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD),
    .BLANK_LZ    (1'b1)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] sb_q[$];

  int unsigned m_ps, m_slot;
  logic [3:0]  m_o, m_t;
  logic [1:0]  m_h;
  int unsigned g_ps, g_slot;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n, input bit blank);
    logic [6:0] s;
    case (n)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0000110;
    endcase
    if (blank && n <= 4'd9) s = 7'b1111111;
    return s;
  endfunction

  task automatic model_reset();
    m_ps = 0; m_slot = 0; m_o = '0; m_t = '0; m_h = '0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, predict, advance model, compare after posedge.
  task automatic step(input logic ld, input logic [3:0] o, input logic [3:0] t,
                      input logic [1:0] h, input logic en);
    logic [3:0]  an;
    logic [6:0]  sg;
    logic [11:0] e;
    @(negedge CLK);
    RST_N = 1'b1;
    bus.LOAD = ld; bus.ONES = o; bus.TENS = t; bus.HUNDREDS = h; bus.EN = en;
    case (m_slot)
      0: begin an = 4'b1110; sg = ref_seg(m_o, 1'b0); end
      1: begin an = 4'b1101; sg = ref_seg(m_t, (m_h == 2'd0) && (m_t == 4'd0)); end
      2: begin an = 4'b1011; sg = ref_seg({2'b00, m_h}, m_h == 2'd0); end
      default: begin an = 4'b1111; sg = 7'b1111111; end
    endcase
    if (!en || m_ps < GRD) an = 4'b1111;
    sb_q.push_back({an, sg, 1'b1});
    g_ps = m_ps; g_slot = m_slot;
    if (ld) begin m_o = o; m_t = t; m_h = h; end
    if (m_ps == DIV - 1) begin
      m_ps = 0;
      m_slot = (m_slot + 1) % 4;
    end else begin
      m_ps++;
    end
    @(posedge CLK);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_an", bus.AN, e[11:8]);
      chk("sb_seg", bus.SEG, e[7:1]);
      chk("sb_dp", bus.DP, e[0]);
    end
  endtask

  // Load digits, then check 32 cycles against literal per-slot glyphs.
  task automatic run_lit(input string tag, input logic [3:0] o, input logic [3:0] t,
                         input logic [1:0] h, input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2);
    logic [3:0] an_lit[4];
    logic [6:0] seg_lit[4];
    an_lit  = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};
    seg_lit = '{s0, s1, s2, 7'b1111111};
    step(1'b1, o, t, h, 1'b1);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
      chk({tag, "_seg"}, bus.SEG, seg_lit[g_slot]);
      chk({tag, "_an"}, bus.AN, (g_ps < GRD) ? 4'b1111 : an_lit[g_slot]);
    end
  endtask

  initial begin
    bit found;
    bus.LOAD = 1'b0; bus.ONES = '0; bus.TENS = '0; bus.HUNDREDS = '0; bus.EN = 1'b1;
    model_reset();

    // Reset held across clock edges
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_an", bus.AN, 4'b1111);
    chk("rst_seg", bus.SEG, 7'b1111111);
    chk("rst_dp", bus.DP, 1'b1);

    // Asynchronous reset in the middle of slot 1
    step(1'b1, 4'd8, 4'd8, 2'd1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
      if (m_slot == 1 && m_ps == 5) found = 1'b1;
    end
    chk("mid_slot1_reached", found, 1'b1);
    chk("mid_slot1_an", bus.AN, 4'b1101);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_an", bus.AN, 4'b1111);
    chk("arst_seg", bus.SEG, 7'b1111111);
    chk("arst_dp", bus.DP, 1'b1);
    model_reset();

    run_lit("h2t5o5", 4'd5, 4'd5, 2'd2, 7'b0010010, 7'b0010010, 7'b0100100);
    run_lit("h0t0o7", 4'd7, 4'd0, 2'd0, 7'b1111000, 7'b1111111, 7'b1111111);
    run_lit("h0t4o0", 4'd0, 4'd4, 2'd0, 7'b1000000, 7'b0011001, 7'b1111111);
    run_lit("err_ca", 4'hC, 4'hA, 2'd0, 7'b0000110, 7'b0000110, 7'b1111111);

    // Capture on the same edge as the slot 0 -> 1 wrap
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_slot == 0 && m_ps == DIV - 1) found = 1'b1;
      else step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    end
    chk("wrap_sync", found, 1'b1);
    step(1'b1, 4'd9, 4'd3, 2'd1, 1'b1);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    chk("wrap_slot", g_slot, 32'd1);
    chk("wrap_seg_tens", bus.SEG, 7'b0110000);
    chk("wrap_guard_an", bus.AN, 4'b1111);
    repeat (2) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    chk("wrap_active_an", bus.AN, 4'b1101);

    // Display disabled for 10 cycles, then resumes in phase
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
      chk("en_off_an", bus.AN, 4'b1111);
    end
    repeat (24) step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
